// File: rtl/mux_scan_controller.sv
// Time-multiplexed reader for a 4-to-1 mux: steps the select through all four
// channels, captures one bit per channel and presents the 4-bit word with a valid pulse.
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [1:0] s,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 16) begin : g_bad_settle
        $error("mux_scan_controller: SETTLE_CYCLES must be in 1..16");
    end

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] s_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] shadow, shadow_nxt;
    logic [3:0] sample_nxt;
    logic       valid_nxt;
    logic       busy_nxt;

    // Handshake: start is accepted only in IDLE; valid is a one-cycle strobe
    // with sample stable from that cycle until the next strobe (no back-pressure).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= 2'b00;
            cnt    <= 4'd0;
            shadow <= 4'b0000;
            sample <= 4'b0000;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            s      <= s_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            sample <= sample_nxt;
            valid  <= valid_nxt;
            busy   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_nxt      = s;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        sample_nxt = sample;
        valid_nxt  = 1'b0;
        busy_nxt   = busy;

        case (state)
            IDLE: begin
                s_nxt = 2'b00;
                if (start) begin
                    state_nxt  = SCAN;
                    cnt_nxt    = RELOAD;
                    shadow_nxt = 4'b0000;
                    busy_nxt   = 1'b1;
                end
            end

            SCAN: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // Capture on the last edge of the window so the mux gets the full hold time.
                    shadow_nxt[s] = mux_out;
                    if (s != 2'b11) begin
                        s_nxt   = s + 2'b01;
                        cnt_nxt = RELOAD;
                    end else begin
                        sample_nxt = shadow_nxt;
                        valid_nxt  = 1'b1;
                        s_nxt      = 2'b00;
                        state_nxt  = DONE;
                    end
                end
            end

            DONE: begin
                s_nxt      = 2'b00;
                shadow_nxt = 4'b0000;
                if (continuous) begin
                    state_nxt = SCAN;
                    cnt_nxt   = RELOAD;
                end else begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
                s_nxt     = 2'b00;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: two instances (SETTLE_CYCLES = 1 and 3), each
// fed by a behavioural mux, checked against sweep-level expectations.
module tb_mux_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start3, cont1, cont3;
    logic [3:0] data1, data3;
    logic       mux1, mux3;
    logic [1:0] s1, s3;
    logic [3:0] sample1, sample3;
    logic       valid1, valid3, busy1, busy3;

    assign mux1 = data1[s1];
    assign mux3 = data3[s3];

    mux_scan_controller #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1), .mux_out(mux1),
        .s(s1), .sample(sample1), .valid(valid1), .busy(busy1)
    );

    mux_scan_controller #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .continuous(cont3), .mux_out(mux3),
        .s(s3), .sample(sample3), .valid(valid3), .busy(busy3)
    );

    int vectors = 0;
    int errors  = 0;
    bit sel;

    logic [1:0] s_o;
    logic [3:0] sample_o;
    logic       valid_o, busy_o;
    assign s_o      = sel ? s3 : s1;
    assign sample_o = sel ? sample3 : sample1;
    assign valid_o  = sel ? valid3 : valid1;
    assign busy_o   = sel ? busy3 : busy1;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel ? 3 : 1, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start3 = v; else start1 = v;
    endtask

    task automatic set_data(input logic [3:0] v);
        if (sel) data3 = v; else data1 = v;
    endtask

    task automatic set_cont(input logic v);
        if (sel) cont3 = v; else cont1 = v;
    endtask

    // One sweep starting in the first SCAN cycle; channel k is held for S cycles
    // and must read data[k] at the end of its window.
    task automatic scan(input logic [3:0] data, input bit glitch, input bit noise);
        int S;
        S = sel ? 3 : 1;
        for (int t = 0; t < 4 * S; t++) begin
            chk("scan_s", {2'b00, s_o}, 4'(t / S));
            chk("scan_busy", {3'b000, busy_o}, 4'd1);
            chk("scan_valid", {3'b000, valid_o}, 4'd0);
            if (glitch && (t % S != S - 1)) set_data(4'($urandom_range(0, 15)));
            else set_data(data);
            if (noise && t < 4 * S - 1) set_start(1'($urandom_range(0, 1)));
            else set_start(1'b0);
            tick();
        end
        set_start(1'b0);
        chk("done_valid", {3'b000, valid_o}, 4'd1);
        chk("done_sample", sample_o, data);
        chk("done_busy", {3'b000, busy_o}, 4'd1);
        chk("done_s", {2'b00, s_o}, 4'd0);
    endtask

    task automatic sweep(input logic [3:0] data, input bit glitch, input bit noise);
        set_data(data);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        scan(data, glitch, noise);
    endtask

    task automatic finish_idle(input logic [3:0] data);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("idle_valid", {3'b000, valid_o}, 4'd0);
            chk("idle_busy", {3'b000, busy_o}, 4'd0);
            chk("idle_s", {2'b00, s_o}, 4'd0);
            chk("idle_sample", sample_o, data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d, nd;
        int n;
        rst_n = 1'b0;
        start1 = 1'b0; start3 = 1'b0; cont1 = 1'b0; cont3 = 1'b0;
        data1 = 4'd0; data3 = 4'd0;
        sel = 1'b0;
        #12;
        chk("rst_s1", {2'b00, s1}, 4'd0);
        chk("rst_sample1", sample1, 4'd0);
        chk("rst_vb1", {2'b00, valid1, busy1}, 4'd0);
        chk("rst_s3", {2'b00, s3}, 4'd0);
        chk("rst_sample3", sample3, 4'd0);
        chk("rst_vb3", {2'b00, valid3, busy3}, 4'd0);
        rst_n = 1'b1;
        finish_idle(4'b0000);

        // Single sweeps at both settle lengths
        sel = 1'b0; sweep(4'b1010, 1'b0, 1'b0); finish_idle(4'b1010);
        sel = 1'b1; sweep(4'b0110, 1'b0, 1'b0); finish_idle(4'b0110);

        // Continuous: data changes in DONE, continuous dropped during second sweep
        sel = 1'b0;
        set_cont(1'b1);
        sweep(4'b0001, 1'b0, 1'b0);
        set_data(4'b1000);
        tick();
        chk("cont_valid", {3'b000, valid_o}, 4'd0);
        chk("cont_busy", {3'b000, busy_o}, 4'd1);
        chk("cont_s", {2'b00, s_o}, 4'd0);
        chk("cont_hold", sample_o, 4'b0001);
        set_cont(1'b0);
        scan(4'b1000, 1'b0, 1'b0);
        finish_idle(4'b1000);

        // start noise while busy, then glitches inside long windows
        sel = 1'b1; sweep(4'b1001, 1'b0, 1'b1); finish_idle(4'b1001);
        sel = 1'b1; sweep(4'b0000, 1'b1, 1'b0); finish_idle(4'b0000);

        // Asynchronous reset in the middle of channel 2
        sel = 1'b1;
        set_data(4'b1100);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (6) tick();
        chk("pre_rst_s", {2'b00, s_o}, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s3", {2'b00, s3}, 4'd0);
        chk("arst_vb3", {2'b00, valid3, busy3}, 4'd0);
        chk("arst_sample3", sample3, 4'd0);
        chk("arst_sample1", sample1, 4'd0);
        tick();
        rst_n = 1'b1;
        finish_idle(4'b0000);
        sweep(4'b0011, 1'b0, 1'b0);
        finish_idle(4'b0011);

        // Randomized sweeps and continuous chains
        repeat (24) begin
            sel = 1'($urandom_range(0, 1));
            #1;
            n = $urandom_range(1, 3);
            d = 4'($urandom_range(0, 15));
            set_cont(n > 1);
            sweep(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 1; k < n; k++) begin
                nd = 4'($urandom_range(0, 15));
                set_data(nd);
                tick();
                chk("rcont_valid", {3'b000, valid_o}, 4'd0);
                chk("rcont_busy", {3'b000, busy_o}, 4'd1);
                chk("rcont_hold", sample_o, d);
                if (k == n - 1) set_cont(1'b0);
                scan(nd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                d = nd;
            end
            finish_idle(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
- Sequencer placed around the 4-to-1 multiplexer: drives its 2-bit select `s`, samples its 1-bit `out` once per channel, and assembles the four samples into a 4-bit word.
- Turns the mux into a time-multiplexed 4-channel reader with a start/valid handshake.
- Supports single-sweep and continuous-sweep modes.
- Sits upstream of the mux for select generation and downstream of it for data capture.

Parameters:
- SETTLE_CYCLES, 1: clock cycles each select value is held before `mux_out` is captured. Legal range 1..16; 4-bit down-counter.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- continuous  input  1  1 = start a new sweep automatically after each completed sweep; sampled in DONE
- mux_out  input  1  output of the 4-to-1 mux
- s  output  2  select driven to the mux
- sample  output  4  assembled word; bit k = `mux_out` captured while s = k
- valid  output  1  high for exactly one cycle when `sample` is updated
- busy  output  1  high in SCAN and DONE

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, s = 2'b00, sample = 4'b0000, internal shadow = 4'b0000, counter = 0, valid = 0, busy = 0. Takes effect immediately, including mid-sweep. The partial shadow is discarded and `sample` is not updated.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - s = 00, valid = 0, busy = 0.
  - On a clock edge with start = 1: go to SCAN, s = 00, counter = SETTLE_CYCLES-1, busy = 1.
- SCAN, each edge:
  - If counter != 0: counter decrements; s holds.
  - If counter == 0: shadow[s] <= mux_out.
    - If s != 11: s <= s+1, counter <= SETTLE_CYCLES-1.
    - If s == 11: sample <= {mux_out, shadow[2:0]}, valid <= 1, s <= 00, go to DONE.
- Capture timing: each select value is held for exactly SETTLE_CYCLES cycles. Capture happens at the last edge of that window, so the mux has SETTLE_CYCLES-1 full cycles plus one cycle to settle.
- Latency: if start is sampled at edge E0, valid is high in the cycle following edge E0 + 4*SETTLE_CYCLES.
- DONE (one cycle; valid = 1, busy = 1):
  - If continuous = 1: go to SCAN with s = 00, counter reloaded, valid <= 0.
  - Else: go to IDLE, valid <= 0, busy <= 0.
  - Consecutive continuous sweeps are separated by exactly one DONE cycle. Sweep period = 4*SETTLE_CYCLES + 1 cycles.
- `start` in SCAN or DONE is ignored; no queuing.
- `continuous` deasserted during SCAN: the current sweep completes normally, then the block returns to IDLE.
- `sample` holds its value between valid pulses and through IDLE.
- `mux_out` changing mid-window: only the value present at the capture edge is recorded.
- SETTLE_CYCLES outside 1..16 is illegal. The implementation must flag it with an elaboration-time error.

Test Plan:
1. SETTLE_CYCLES = 1, mux i = 4'b1010, start pulsed 1 cycle:
   - s steps 00, 01, 10, 11, one cycle each.
   - valid high exactly one cycle, 4 edges after the start edge.
   - sample = 4'b1010, busy falls the cycle after valid, s returns to 00.
2. SETTLE_CYCLES = 3, i = 4'b0110:
   - Each s value is held 3 cycles.
   - valid appears 12 edges after the start edge; sample = 4'b0110.
3. continuous = 1, SETTLE_CYCLES = 1, i = 4'b0001 for the first sweep, then changed to 4'b1000 during DONE:
   - First valid gives sample = 0001; second valid, 5 cycles later, gives sample = 1000.
   - Deassert continuous during the second sweep: return to IDLE after it.
4. start re-pulsed while busy = 1: no restart, s sequence undisturbed, exactly one valid.
5. rst_n pulled low while s = 10 mid-sweep:
   - s, valid and busy go to 0 immediately, asynchronously; sample = 0000.
   - After release, a new start gives a correct sweep.
6. mux_out glitches high for one cycle early in a SETTLE_CYCLES = 3 window but is 0 at the capture edge: the corresponding sample bit = 0.
